// File: rtl/decode_queue_pkg.sv
// decode_queue_pkg: shared op constants, opcodes and decoded record type
package decode_queue_pkg;
  typedef enum logic [5:0] {
    OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
    OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
    OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
    OP_SB, OP_SH, OP_SW,
    OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI, OP_SLLI, OP_SRLI, OP_SRAI,
    OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND,
    OP_ILLEGAL
  } op_t;
  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_AUIPC  = 7'h17;
  localparam logic [6:0] OPC_JAL    = 7'h6f;
  localparam logic [6:0] OPC_JALR   = 7'h67;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_IMM    = 7'h13;
  localparam logic [6:0] OPC_OP     = 7'h33;
  typedef struct packed {
    op_t         op;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic        use_rs1;
    logic        use_rs2;
    logic        wr_rd;
    logic        illegal;
  } dec_t;
endpackage

// File: rtl/decode_queue_core.sv
// decode_core: combinational RV32I decoder producing the queued record
module decode_core
  import decode_queue_pkg::*;
(
  input  logic [31:0] inst,
  output dec_t        rec
);
  logic [6:0] opc;
  logic [2:0] f3;
  logic [6:0] f7;
  logic [31:0] i_imm, s_imm, b_imm, u_imm, j_imm;
  op_t op;
  logic [31:0] imm;
  logic ill, br, st;
  assign opc = inst[6:0];
  assign f3 = inst[14:12];
  assign f7 = inst[31:25];
  assign i_imm = {{20{inst[31]}}, inst[31:20]};
  assign s_imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
  assign b_imm = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
  assign u_imm = {inst[31:12], 12'b0};
  assign j_imm = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
  // op selection and raw immediate per instruction format
  always_comb begin
    op = OP_ILLEGAL;
    imm = '0;
    case (opc)
      OPC_LUI:   begin op = OP_LUI; imm = u_imm; end
      OPC_AUIPC: begin op = OP_AUIPC; imm = u_imm; end
      OPC_JAL:   begin op = OP_JAL; imm = j_imm; end
      OPC_JALR:  begin op = f3 == 3'd0 ? OP_JALR : OP_ILLEGAL; imm = i_imm; end
      OPC_BRANCH: begin
        imm = b_imm;
        case (f3)
          3'd0: op = OP_BEQ;
          3'd1: op = OP_BNE;
          3'd4: op = OP_BLT;
          3'd5: op = OP_BGE;
          3'd6: op = OP_BLTU;
          3'd7: op = OP_BGEU;
          default: op = OP_ILLEGAL;
        endcase
      end
      OPC_LOAD: begin
        imm = i_imm;
        case (f3)
          3'd0: op = OP_LB;
          3'd1: op = OP_LH;
          3'd2: op = OP_LW;
          3'd4: op = OP_LBU;
          3'd5: op = OP_LHU;
          default: op = OP_ILLEGAL;
        endcase
      end
      OPC_STORE: begin
        imm = s_imm;
        case (f3)
          3'd0: op = OP_SB;
          3'd1: op = OP_SH;
          3'd2: op = OP_SW;
          default: op = OP_ILLEGAL;
        endcase
      end
      OPC_IMM: begin
        imm = i_imm;
        case (f3)
          3'd0: op = OP_ADDI;
          3'd1: op = f7 == 7'h00 ? OP_SLLI : OP_ILLEGAL;
          3'd2: op = OP_SLTI;
          3'd3: op = OP_SLTIU;
          3'd4: op = OP_XORI;
          3'd5: op = f7 == 7'h00 ? OP_SRLI : f7 == 7'h20 ? OP_SRAI : OP_ILLEGAL;
          3'd6: op = OP_ORI;
          default: op = OP_ANDI;
        endcase
      end
      OPC_OP: begin
        if (f7 == 7'h00)
          case (f3)
            3'd0: op = OP_ADD;
            3'd1: op = OP_SLL;
            3'd2: op = OP_SLT;
            3'd3: op = OP_SLTU;
            3'd4: op = OP_XOR;
            3'd5: op = OP_SRL;
            3'd6: op = OP_OR;
            default: op = OP_AND;
          endcase
        else if (f7 == 7'h20)
          op = f3 == 3'd0 ? OP_SUB : f3 == 3'd5 ? OP_SRA : OP_ILLEGAL;
      end
      default: op = OP_ILLEGAL;
    endcase
  end
  assign ill = op == OP_ILLEGAL;
  assign br = opc == OPC_BRANCH;
  assign st = opc == OPC_STORE;
  assign rec.op = op;
  assign rec.rs1 = inst[19:15];
  assign rec.rs2 = inst[24:20];
  assign rec.imm = ill ? '0 : imm;
  assign rec.illegal = ill;
  assign rec.use_rs1 = !ill && opc != OPC_LUI && opc != OPC_AUIPC && opc != OPC_JAL;
  assign rec.use_rs2 = !ill && (br || st || opc == OPC_OP);
  assign rec.wr_rd = !ill && !br && !st && inst[11:7] != 5'd0;
  assign rec.rd = rec.wr_rd ? inst[11:7] : 5'd0;
endmodule

// File: rtl/decode_queue.sv
// decode_queue: decode-at-enqueue FIFO of RV32I instruction records
module decode_queue
  import decode_queue_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic             flush_in,
  input  logic             fetch_valid,
  input  logic [31:0]      fetch_inst,
  input  logic [31:0]      fetch_pc,
  output logic             fetch_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [5:0]       out_op_type,
  output logic [4:0]       out_rs1,
  output logic [4:0]       out_rs2,
  output logic [4:0]       out_rd,
  output logic [31:0]      out_imm,
  output logic [31:0]      out_pc,
  output logic             out_use_rs1,
  output logic             out_use_rs2,
  output logic             out_wr_rd,
  output logic             out_illegal,
  output logic [CNT_W-1:0] count_out
);
  localparam int AW = $clog2(DEPTH);
  dec_t dec, head;
  dec_t rec_mem [DEPTH];
  logic [31:0] pc_mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic push, pop;
  decode_core u_core (.inst(fetch_inst), .rec(dec));
  assign fetch_ready = count < CNT_W'(DEPTH);
  assign out_valid = count != '0;
  assign push = rdy_in && !flush_in && fetch_valid && fetch_ready;
  assign pop = rdy_in && !flush_in && out_valid && out_ready;
  assign head = out_valid ? rec_mem[rd_ptr] : '0;
  assign out_pc = out_valid ? pc_mem[rd_ptr] : '0;
  assign out_op_type = head.op;
  assign out_rs1 = head.rs1;
  assign out_rs2 = head.rs2;
  assign out_rd = head.rd;
  assign out_imm = head.imm;
  assign out_use_rs1 = head.use_rs1;
  assign out_use_rs2 = head.use_rs2;
  assign out_wr_rd = head.wr_rd;
  assign out_illegal = head.illegal;
  assign count_out = count;
  // pointers and occupancy; flush empties the queue and drops same-cycle handshakes
  always_ff @(posedge clk_in) begin
    if (rst_in || (rdy_in && flush_in)) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end
  // record storage written at the tail on enqueue
  always_ff @(posedge clk_in) begin
    if (push) begin
      rec_mem[wr_ptr] <= dec;
      pc_mem[wr_ptr] <= fetch_pc;
    end
  end
endmodule
